// File: rtl/rare_trigger_monitor.sv
// rare_trigger_monitor: per-lane delay pipelines feeding an A&C&~B
// hit detector, with a run-length trigger FSM and registered outputs.
module rare_trigger_monitor #(
  parameter int WIDTH  = 4,
  parameter int DEPTH  = 2,
  parameter int THRESH = 3,
  localparam int CW    = $clog2(THRESH + 1)
) (
  input  logic             I1470,
  input  logic             I1477,
  input  logic [WIDTH-1:0] din_a,
  input  logic [WIDTH-1:0] din_b,
  input  logic [WIDTH-1:0] din_c,
  input  logic             enable,
  input  logic             clear,
  output logic             trig_out,
  output logic             fired,
  output logic [CW-1:0]    hit_count,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    FIRED = 2'd2,
    BAD   = 2'd3
  } state_e;

  localparam logic [CW-1:0] THR = CW'(THRESH);
  localparam logic [CW-1:0] ONE = CW'(1);

  logic [WIDTH-1:0] a_pipe_q [DEPTH];
  logic [WIDTH-1:0] b_pipe_q [DEPTH];
  logic [WIDTH-1:0] c_pipe_q [DEPTH];
  logic [WIDTH-1:0] a_pipe_d [DEPTH];
  logic [WIDTH-1:0] b_pipe_d [DEPTH];
  logic [WIDTH-1:0] c_pipe_d [DEPTH];

  logic [WIDTH-1:0] a_last;
  logic [WIDTH-1:0] b_last;
  logic [WIDTH-1:0] c_last;
  logic [WIDTH-1:0] x_n;
  logic [WIDTH-1:0] cond;
  logic             hit;
  logic             go;

  state_e        state_q;
  state_e        state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [CW-1:0] cnt_inc;
  logic          fired_q;
  logic          fired_d;
  logic          trig_q;
  logic          trig_d;

  // Shift each operand one stage per cycle, independent of FSM state.
  always_comb begin
    a_pipe_d[0] = din_a;
    b_pipe_d[0] = din_b;
    c_pipe_d[0] = din_c;
    for (int i = 1; i < DEPTH; i++) begin
      a_pipe_d[i] = a_pipe_q[i-1];
      b_pipe_d[i] = b_pipe_q[i-1];
      c_pipe_d[i] = c_pipe_q[i-1];
    end
  end

  // Pipeline registers; only reset flushes them, clear does not.
  always_ff @(posedge I1470) begin
    if (I1477) begin
      for (int i = 0; i < DEPTH; i++) begin
        a_pipe_q[i] <= '0;
        b_pipe_q[i] <= '0;
        c_pipe_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        a_pipe_q[i] <= a_pipe_d[i];
        b_pipe_q[i] <= b_pipe_d[i];
        c_pipe_q[i] <= c_pipe_d[i];
      end
    end
  end

  // Lane condition: NOR(NAND(a,c), b) == a & c & ~b, ORed across lanes.
  always_comb begin
    a_last  = a_pipe_q[DEPTH-1];
    b_last  = b_pipe_q[DEPTH-1];
    c_last  = c_pipe_q[DEPTH-1];
    x_n     = ~(a_last & c_last);
    cond    = ~(x_n | b_last);
    hit     = |cond;
    go      = enable & hit;
    cnt_inc = cnt_q + ONE;
  end

  // FSM and output registers.
  always_ff @(posedge I1470) begin
    if (I1477) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      fired_q <= 1'b0;
      trig_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fired_q <= fired_d;
      trig_q  <= trig_d;
    end
  end

  // Next state: clear wins; FIRED is sticky; state 3 recovers to IDLE.
  always_comb begin
    state_d = IDLE;
    if (clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (go) state_d = (ONE == THR) ? FIRED : ARMED;
          else    state_d = IDLE;
        end
        ARMED: begin
          if (go) state_d = (cnt_inc == THR) ? FIRED : ARMED;
          else    state_d = IDLE;
        end
        FIRED:   state_d = FIRED;
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs: count follows the run, pulse only on entry to FIRED.
  always_comb begin
    cnt_d   = '0;
    fired_d = (state_d == FIRED);
    trig_d  = (state_d == FIRED) && (state_q != FIRED);
    if (!clear) begin
      case (state_q)
        IDLE:    cnt_d = go ? ONE : '0;
        ARMED:   cnt_d = go ? cnt_inc : '0;
        FIRED:   cnt_d = THR;
        default: cnt_d = '0;
      endcase
    end
  end

  assign trig_out  = trig_q;
  assign fired     = fired_q;
  assign hit_count = cnt_q;
  assign state     = state_q;

endmodule

// File: doc/rare_trigger_monitor.md
RARE_TRIGGER_MONITOR -- requirements
Module: rare_trigger_monitor

Interface
REQ-001 The module SHALL have parameter WIDTH, default 4: number of monitored lanes; legal range 1..64.
REQ-002 The module SHALL have parameter DEPTH, default 2: input delay-pipeline stages per lane; legal range 1..16.
REQ-003 The module SHALL have parameter THRESH, default 3: consecutive hit cycles needed to fire; legal range 1..255.
REQ-004 The module SHALL have local parameter CW = clog2(THRESH+1), the counter width.
REQ-005 The module SHALL have port I1470, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-006 The module SHALL have port I1477, input, 1 bit: reset, synchronous and active-high.
REQ-007 The module SHALL have port din_a, input, WIDTH bits: lane operand A.
REQ-008 The module SHALL have port din_b, input, WIDTH bits: lane operand B (inhibit).
REQ-009 The module SHALL have port din_c, input, WIDTH bits: lane operand C.
REQ-010 The module SHALL have port enable, input, 1 bit: arms detection.
REQ-011 The module SHALL have port clear, input, 1 bit: releases FIRED and clears the counter.
REQ-012 The module SHALL have port trig_out, output, 1 bit: registered one-cycle fire pulse.
REQ-013 The module SHALL have port fired, output, 1 bit: registered sticky fire flag.
REQ-014 The module SHALL have port hit_count, output, CW bits: current consecutive-hit count.
REQ-015 The module SHALL have port state, output, 2 bits: FSM state encoded IDLE=0, ARMED=1, FIRED=2; value 3 is unused.

Function
REQ-016 Each of din_a, din_b and din_c SHALL pass through its own DEPTH-stage register pipeline, and the pipeline SHALL run every cycle regardless of enable or state.
REQ-017 Per lane, the module SHALL compute x[i] = NAND(a_d[i], c_d[i]) from the last pipeline stage.
REQ-018 Per lane, the module SHALL compute cond[i] = NOR(x[i], b_d[i]), which is equivalent to a_d & c_d & ~b_d.
REQ-019 hit SHALL be the OR of cond[WIDTH-1:0], taken combinationally from the last pipeline stage.
REQ-020 An input vector sampled at edge n SHALL be reflected in hit during the cycle after edge n+DEPTH-1.
REQ-021 In IDLE with enable=1 and hit=1, the next edge SHALL load hit_count=1 and move to ARMED, or to FIRED when THRESH=1.
REQ-022 In IDLE with enable=0 or hit=0, state SHALL stay IDLE and hit_count SHALL stay 0.
REQ-023 In ARMED with enable=1 and hit=1, the next edge SHALL increment hit_count.
REQ-024 When the incremented hit_count equals THRESH, the module SHALL enter FIRED, set fired=1 and set trig_out=1 for exactly one cycle.
REQ-025 In ARMED with hit=0 or enable=0, the next edge SHALL return to IDLE with hit_count=0.
REQ-026 In FIRED, hit_count SHALL hold THRESH, fired SHALL hold 1, and trig_out SHALL be 0 after the first cycle.
REQ-027 FIRED SHALL ignore hit and enable, and no re-fire SHALL occur until clear.
REQ-028 clear=1 SHALL force state=IDLE, hit_count=0, fired=0 and trig_out=0 at the next edge from any state, taking priority over hit and enable.
REQ-029 clear SHALL NOT flush the pipelines.
REQ-030 clear and a completing hit in the same cycle SHALL resolve as clear: no trig_out pulse and fired stays 0.
REQ-031 hit_count SHALL never exceed THRESH and SHALL never wrap.
REQ-032 State 3 SHALL recover to IDLE with hit_count=0 at the next edge.
REQ-033 All outputs SHALL be driven directly from registers.

Reset
REQ-034 I1477=1 at a rising edge SHALL clear all pipeline stages to 0 and set state=IDLE, hit_count=0, fired=0 and trig_out=0.
REQ-035 Reset SHALL take priority over clear, enable and hit.
REQ-036 Reset asserted mid-ARMED or in FIRED SHALL abort the sequence, and no trig_out pulse SHALL follow.
REQ-037 After reset releases, hit SHALL be 0 for at least DEPTH cycles because the pipelines are zero-filled.

Verification (WIDTH=4, DEPTH=2, THRESH=3)
REQ-038 Fire test: with enable=1, drive din_a=4'b0010, din_c=4'b0010, din_b=0 for 3 cycles; hit_count SHALL step 1, 2, 3, trig_out SHALL pulse once on the third counting edge, and state SHALL become 2.
REQ-039 Inhibit-gap test: drive the firing pattern for 2 cycles, then din_b=4'b0010 for 1 cycle, then the pattern again; hit_count SHALL go 1, 2, 0, 1 with no trig_out.
REQ-040 Clear-collision test: assert clear in the cycle the third hit is evaluated; the result SHALL be IDLE, hit_count=0, fired=0 and no pulse.
REQ-041 Reset test: assert I1477 while hit_count=2; all outputs SHALL be 0 after the edge, and hit SHALL stay 0 for 2 cycles even with the firing pattern applied.
REQ-042 FIRED-hold test: after firing, hold enable=0 and apply random inputs for 20 cycles; fired SHALL stay 1, trig_out SHALL stay 0 and hit_count SHALL stay 3.
REQ-043 Enable-drop test: in ARMED with hit_count=1, drop enable for 1 cycle; the module SHALL return to IDLE with hit_count=0.
